multi_blink_ctrl: RTL and testbench

- Parametrised multi-channel LED blinker for the DE-board LED banks.
- Each channel has its own mode and half-period, set through a one-cycle config write port. Half-periods are counted in ticks from a shared prescaler.
- Adds always-on, one-shot, global enable/freeze and phase resync.
- The top level drives CLOCK_50 and wires RESET_N to KEY[0]. SW and KEY drive the config port; led_out drives LEDR/LEDG.

---
 rtl/multi_blink_ctrl.sv | 145 ++++++++++++++
 tb/tb_multi_blink_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_blink_ctrl.sv
// rtl/multi_blink_ctrl.sv - multi-channel LED blinker with shared tick prescaler
//
// Purpose:
//   N_CH independent LED channels. Each channel is OFF, ON, BLINK or ONESHOT
//   with its own half-period in ticks. The tick comes from a shared prescaler
//   that divides CLOCK_50 by DIV = CLK_FREQ/TICK_HZ.
//
// Ports:
//   CLOCK_50  in   system clock
//   RESET_N   in   asynchronous active-low reset
//   en        in   global enable; 0 freezes prescaler, counters and LEDs
//   sync      in   one-cycle pulse; realigns all channel phases
//   cfg_we    in   one-cycle config write strobe
//   cfg_ch    in   [3:0] target channel (writes to cfg_ch >= N_CH are ignored)
//   cfg_mode  in   [1:0] 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//   cfg_half  in   [PER_W-1:0] half-period / one-shot length in ticks
//   led_out   out  [N_CH-1:0] registered LED drive, 1 = lit
//   tick      out  registered one-cycle pulse per tick period
module multi_blink_ctrl #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1000,
    parameter int N_CH     = 10,
    parameter int PER_W    = 12
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_half,
    output logic [N_CH-1:0]  led_out,
    output logic             tick
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    logic [PRE_W-1:0] r_pre;
    logic             r_tick;

    mode_t            r_mode [N_CH];
    logic [PER_W-1:0] r_half [N_CH];
    logic [PER_W-1:0] r_cnt  [N_CH];
    logic [N_CH-1:0]  r_led;

    logic [PER_W-1:0] w_last [N_CH];
    logic             w_adv;

    // Terminal count is heff-1, where a half of 0 behaves as 1.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_last[i] = '0;
            if (r_half[i] != '0) begin
                w_last[i] = r_half[i] - 1'b1;
            end
        end
    end

    // A tick only advances channels while enabled, and sync on the same
    // edge swallows it.
    assign w_adv = r_tick & en & ~sync;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (sync) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_pre == PRE_LAST) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Per-channel priority: config write > sync > tick.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_CH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_half[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_led <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (cfg_ch == 4'(i))) begin
                    r_mode[i] <= mode_t'(cfg_mode);
                    r_half[i] <= cfg_half;
                    r_cnt[i]  <= '0;
                    r_led[i]  <= (cfg_mode != 2'd0);
                end else if (sync) begin
                    r_cnt[i] <= '0;
                    if (r_mode[i] == MODE_BLINK) begin
                        r_led[i] <= 1'b1;
                    end
                end else if (w_adv) begin
                    case (r_mode[i])
                        MODE_BLINK: begin
                            if (r_cnt[i] == w_last[i]) begin
                                r_cnt[i] <= '0;
                                r_led[i] <= ~r_led[i];
                            end else begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                        MODE_ONESHOT: begin
                            if (r_cnt[i] == w_last[i]) begin
                                r_cnt[i]  <= '0;
                                r_led[i]  <= 1'b0;
                                r_mode[i] <= MODE_OFF;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                        default: begin
                            r_cnt[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign led_out = r_led;
    assign tick    = r_tick;

endmodule

// File: tb/tb_multi_blink_ctrl.sv
// tb/tb_multi_blink_ctrl.sv - randomized bench for multi_blink_ctrl against a tick-phase model
module tb_multi_blink_ctrl;

    localparam int NCH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_half = '0;
    logic [3:0] led_out;
    logic       tick;

    always #5 clk = ~clk;

    multi_blink_ctrl #(
        .CLK_FREQ(1000),
        .TICK_HZ (100),
        .N_CH    (NCH),
        .PER_W   (8)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_mode(cfg_mode),
        .cfg_half(cfg_half),
        .led_out (led_out),
        .tick    (tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: each channel remembers how many ticks it has seen since
    // its last write/sync (m_ph); the LED is derived from that count.
    int m_mode [NCH];
    int m_half [NCH];
    int m_ph   [NCH];
    bit m_led  [NCH];
    int m_pre;
    bit m_tick;

    function automatic logic [3:0] m_leds();
        logic [3:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_led[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_half[c] = 0; m_ph[c] = 0; m_led[c] = 0;
        end
        m_pre  = 0;
        m_tick = 0;
    endtask

    task automatic model_step();
        bit adv;
        int heff;
        adv = m_tick && en && !sync;
        for (int c = 0; c < NCH; c++) begin
            heff = (m_half[c] == 0) ? 1 : m_half[c];
            if (cfg_we && int'(cfg_ch) == c) begin
                m_mode[c] = int'(cfg_mode);
                m_half[c] = int'(cfg_half);
                m_ph[c]   = 0;
                m_led[c]  = (cfg_mode != 0);
            end else if (sync) begin
                m_ph[c] = 0;
                if (m_mode[c] == 2) m_led[c] = 1;
            end else if (adv && m_mode[c] >= 2) begin
                m_ph[c]++;
                if (m_mode[c] == 2) begin
                    m_led[c] = ((m_ph[c] / heff) % 2) == 0;
                end else if (m_ph[c] >= heff) begin
                    m_mode[c] = 0; m_led[c] = 0; m_ph[c] = 0;
                end
            end
        end
        if (sync) begin
            m_pre = 0; m_tick = 0;
        end else if (en) begin
            if (m_pre == 9) begin m_pre = 0; m_tick = 1; end
            else begin m_pre++; m_tick = 0; end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("led_out", 32'(led_out), 32'(m_leds()));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input int ch, input int mode, input int half);
        cfg_we = 1; cfg_ch = 4'(ch); cfg_mode = 2'(mode); cfg_half = 8'(half);
        cyc();
        cfg_we = 0;
    endtask

    task automatic wait_model_tick();
        int k;
        k = 0;
        while (!m_tick && k < 20) begin cyc(); k++; end
        chk("tick_wait_bound", 32'(m_tick), 32'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        chk("rst_led_async", 32'(led_out), 32'd0);
        chk("rst_tick_async", 32'(tick), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led_hold", 32'(led_out), 32'd0);
        chk("rst_tick_hold", 32'(tick), 32'd0);
        rst_n = 1;
    endtask

    initial begin
        int first, cnt;
        model_reset();
        en = 1;
        @(posedge clk); #1;

        // 1. reset and first tick latency
        do_reset();
        first = -1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            cyc();
            if (tick) first = k;
        end
        chk("first_tick_latency", 32'(first), 32'd10);

        // 2. blink
        wr(0, 2, 3);
        chk("blink_lit_after_write", 32'(led_out[0]), 32'd1);
        run(100);
        wr(1, 2, 0);
        run(40);

        // 3. oneshot and relight
        wr(2, 3, 5);
        run(60);
        chk("oneshot_done", 32'(led_out[2]), 32'd0);
        run(200);
        chk("oneshot_stays_off", 32'(led_out[2]), 32'd0);
        wr(2, 3, 5);
        chk("oneshot_relit", 32'(led_out[2]), 32'd1);
        run(30);

        // 4. freeze and resync
        wr(0, 2, 4);
        run(20);
        wr(3, 2, 4);
        run(15);
        en = 0;
        run(50);
        en = 1;
        sync = 1; cyc(); sync = 0;
        chk("sync_ch0", 32'(led_out[0]), 32'd1);
        chk("sync_ch3", 32'(led_out[3]), 32'd1);
        run(100);
        chk("sync_in_phase", 32'(led_out[0]), 32'(led_out[3]));

        // 5. collisions
        wr(5, 1, 7);
        run(5);
        wait_model_tick();
        wr(0, 2, 4);
        cnt = 0;
        while (led_out[0] && cnt < 100) begin cyc(); cnt++; end
        chk("write_on_tick_toggle", 32'(cnt), 32'd40);
        wait_model_tick();
        sync = 1; cyc(); sync = 0;
        run(30);

        // async reset mid-blink
        wr(1, 2, 1);
        run(7);
        do_reset();
        run(15);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            sync     = ($urandom_range(0, 49) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = 4'($urandom_range(0, 7));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_half = 8'($urandom_range(0, 6));
            cyc();
        end
        cfg_we = 0; sync = 0; en = 1;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
